// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one two-operand ALU between two requesters.
// Arbitration is round-robin. Add and sub complete in a single ISSUE cycle.
// Multiply is sequenced through the ALU init/done handshake.
// Each response is registered and tagged with the id of the requester that owns it.
// Optional feature: define ALU_MUL_TIMEOUT_EN to enable a multiply watchdog.
// The watchdog aborts a multiply after TIMEOUT_CYCLES cycles in WAIT_MUL and flags rsp_err.
module alu_arbiter #(
  parameter int W              = 3,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [W-1:0]     a0,
  input  logic [W-1:0]     b0,
  input  logic [W-1:0]     a1,
  input  logic [W-1:0]     b1,
  output logic             ack0,
  output logic             ack1,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [2*W-1:0]   rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_init,
  input  logic             alu_done,
  input  logic [2*W-1:0]   alu_out
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_MUL = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;      // id of the requester served most recently
  logic             id_q, id_d;
  logic [W-1:0]     alu_a_q, alu_a_d;
  logic [W-1:0]     alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [2*W-1:0]   rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             grant0, grant1;

`ifdef ALU_MUL_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0]  cnt_q, cnt_d;
`endif

  // Shape the raw ALU result into the 2W-bit response format.
  // Add is zero-extended from its W+1-bit sum.
  // Sub sign-extends the W+1-bit difference, so 2-3 gives all ones and 5-1 gives 4.
  function automatic logic [2*W-1:0] fmt_result(input logic [1:0] op,
                                                input logic [2*W-1:0] res);
    case (op)
      OP_ADD:  fmt_result = {{(W-1){1'b0}}, res[W:0]};
      OP_SUB:  fmt_result = {{(W-1){res[W]}}, res[W:0]};
      default: fmt_result = res;
    endcase
  endfunction

  // Round-robin choice. Port 1 wins a tie only when port 0 was served last.
  always_comb begin
    grant1 = req1 && (!req0 || !last_q);
    grant0 = req0 && !grant1;
  end

  // Next-state and output decode for the sequencing FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    ack0       = 1'b0;
    ack1       = 1'b0;
    alu_init   = 1'b0;
`ifdef ALU_MUL_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) begin
          ack0     = grant0;
          ack1     = grant1;
          id_d     = grant1;
          last_d   = grant1;
          alu_a_d  = grant1 ? a1  : a0;
          alu_b_d  = grant1 ? b1  : b0;
          alu_op_d = grant1 ? op1 : op0;
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        case (alu_op_q)
          OP_MUL: begin
            alu_init = 1'b1;
            state_d  = S_WAIT_MUL;
`ifdef ALU_MUL_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end
          OP_ILL: begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = S_RESP;
          end
          default: begin
            rsp_data_d = fmt_result(alu_op_q, alu_out);
            rsp_err_d  = 1'b0;
            state_d    = S_RESP;
          end
        endcase
      end

      S_WAIT_MUL: begin
        // A done that coincides with watchdog expiry takes priority.
        if (alu_done) begin
          rsp_data_d = alu_out;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end
`ifdef ALU_MUL_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. A synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;          // port 0 wins the first tie after reset
      id_q       <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= 2'b00;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
`ifdef ALU_MUL_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
`ifdef ALU_MUL_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter.
// A behavioural ALU answers the operand bus, and multiply completes after a programmable delay.
// Expected responses are queued when a grant is seen and compared when rsp_valid pulses.
module tb_alu_arbiter;

  localparam int W  = 3;
  localparam int TO = 32;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef struct {
    logic           id;
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] data;
    logic           err;
    int             lat;       // 0: multiply, timed against alu_done instead
    int             ack_cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req0 = 1'b0, req1 = 1'b0;
  logic [1:0]     op0 = '0, op1 = '0;
  logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic           ack0, ack1, rsp_valid, rsp_id, rsp_err, busy, alu_init;
  logic [2*W-1:0] rsp_data;
  logic [W-1:0]   alu_a, alu_b;
  logic [1:0]     alu_op;
  logic           alu_done;
  logic [2*W-1:0] alu_out;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_init(alu_init),
    .alu_done(alu_done), .alu_out(alu_out)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference results: plain 2W-bit arithmetic on zero-extended operands.
  function automatic exp_t model(input logic id, input logic [1:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic timeout, input int cyc);
    exp_t e;
    e.id = id; e.op = op; e.a = a; e.b = b;
    e.err = 1'b0; e.lat = 2; e.ack_cyc = cyc;
    case (op)
      OP_ADD: e.data = {{W{1'b0}}, a} + {{W{1'b0}}, b};
      OP_SUB: e.data = {{W{1'b0}}, a} - {{W{1'b0}}, b};
      OP_MUL: begin
        e.lat = 0;
        if (timeout) begin
          e.data = '0; e.err = 1'b1; e.lat = 2 + TO;
        end else begin
          e.data = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end
      end
      default: begin e.data = '0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // Behavioural ALU. Multiply raises done mul_lat+1 cycles after init; done_en=0 never answers.
  logic done_en = 1'b1;
  int   mul_lat = 1;
  logic mul_busy;
  int   mul_cnt;

  always @(posedge clk) begin
    if (rst) begin
      alu_done <= 1'b0;
      mul_busy <= 1'b0;
      mul_cnt  <= 0;
    end else begin
      alu_done <= 1'b0;
      if (alu_init) begin
        mul_busy <= 1'b1;
        mul_cnt  <= mul_lat;
      end else if (mul_busy) begin
        if (mul_cnt == 0) begin
          mul_busy <= 1'b0;
          alu_done <= done_en;
        end else begin
          mul_cnt <= mul_cnt - 1;
        end
      end
    end
  end

  always_comb begin
    case (alu_op)
      OP_ADD:  alu_out = {{W{1'b0}}, alu_a} + {{W{1'b0}}, alu_b};
      OP_SUB:  alu_out = {{W{1'b0}}, alu_a} - {{W{1'b0}}, alu_b};
      OP_MUL:  alu_out = {{W{1'b0}}, alu_a} * {{W{1'b0}}, alu_b};
      default: alu_out = 6'h2A;   // junk that the arbiter must ignore
    endcase
  end

  // Scoreboard and monitor, sampled on the falling edge.
  exp_t rsp_q[$];
  logic exp_grant[$];
  int   cyc = 0;
  int   ack_count = 0;
  int   init_cnt = 0;
  int   done_cyc = -1;

  always @(negedge clk) begin : monitor
    exp_t e;
    logic g;
    cyc++;
    if (!rst) begin
      if (alu_done) done_cyc = cyc;
      if (alu_init) init_cnt++;
      if (ack0 || ack1) begin
        check("ack_onehot", ack0 & ack1, 0);
        check("ack_while_busy", busy, 0);
        check("grant_expected", exp_grant.size() != 0, 1);
        if (exp_grant.size() != 0) begin
          g = exp_grant.pop_front();
          check("grant_id", ack1, g);
        end
        if (ack1) rsp_q.push_back(model(1'b1, op1, a1, b1, !done_en, cyc));
        else      rsp_q.push_back(model(1'b0, op0, a0, b0, !done_en, cyc));
        init_cnt = 0;
        done_cyc = -1;
        ack_count++;
      end
      if (rsp_valid) begin
        check("rsp_expected", rsp_q.size() != 0, 1);
        if (rsp_q.size() != 0) begin
          e = rsp_q.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", rsp_err, e.err);
          check("alu_op_hold", alu_op, e.op);
          check("alu_a_hold", alu_a, e.a);
          check("alu_b_hold", alu_b, e.b);
          check("init_pulses", init_cnt, (e.op == OP_MUL) ? 1 : 0);
          if (e.lat != 0) check("rsp_latency", cyc - e.ack_cyc, e.lat);
          else            check("mul_after_done", (done_cyc >= 0) && (cyc > done_cyc), 1);
        end
      end
    end
  end

  task automatic wait_acks(input int target);
    int n = 0;
    while (ack_count < target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("ack_wait", ack_count >= target, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rsp_q.size() != 0 || busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_wait", n < 200, 1);
  endtask

  task automatic do_op(input logic port, input logic [1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    int target = ack_count + 1;
    exp_grant.push_back(port);
    if (port) begin op1 = op; a1 = a; b1 = b; req1 = 1'b1; end
    else      begin op0 = op; a0 = a; b0 = b; req0 = 1'b1; end
    wait_acks(target);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_drain();
  endtask

  initial begin
    int target;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_alu_init", alu_init, 0);
    rst = 1'b0;

    // Basic operations, both ports.
    do_op(1'b0, OP_ADD, 3'd3, 3'd2);
    do_op(1'b1, OP_SUB, 3'd2, 3'd3);
    do_op(1'b1, OP_SUB, 3'd5, 3'd1);
    do_op(1'b0, OP_MUL, 3'd7, 3'd7);
    mul_lat = 0;
    do_op(1'b1, OP_MUL, 3'd5, 3'd6);
    mul_lat = 3;
    do_op(1'b0, OP_MUL, 3'd7, 3'd1);
    mul_lat = 1;
    do_op(1'b0, OP_ILL, 3'd4, 3'd4);
    do_op(1'b0, OP_SUB, 3'd0, 3'd7);
    do_op(1'b1, OP_ADD, 3'd7, 3'd7);
    for (int i = 0; i < 10; i++) begin
      mul_lat = $urandom_range(0, 3);
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    do_op(1'b1, OP_ADD, 3'd1, 3'd0);   // port 1 served last before the tie test

    // Both ports held: grants alternate 0,1,0,1.
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
    op0 = OP_ADD; a0 = 3'd1; b0 = 3'd6;
    op1 = OP_MUL; a1 = 3'd3; b1 = 3'd5;
    target = ack_count + 4;
    req0 = 1'b1; req1 = 1'b1;
    wait_acks(target);
    req0 = 1'b0; req1 = 1'b0;
    wait_drain();

`ifdef ALU_MUL_TIMEOUT_EN
    // Multiply with no done ever returned: watchdog error.
    done_en = 1'b0;
    do_op(1'b0, OP_MUL, 3'd3, 3'd3);
    done_en = 1'b1;
`endif

    // Reset while waiting on a multiply.
    done_en = 1'b0;
    exp_grant.push_back(1'b0);
    op0 = OP_MUL; a0 = 3'd6; b0 = 3'd5;
    target = ack_count + 1;
    req0 = 1'b1;
    wait_acks(target);
    req0 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_wait_mul", busy & ~alu_init & ~rsp_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_rsp_id", rsp_id, 0);
    check("abort_rsp_data", rsp_data, 0);
    check("abort_rsp_err", rsp_err, 0);
    check("abort_alu_a", alu_a, 0);
    check("abort_alu_b", alu_b, 0);
    check("abort_alu_op", alu_op, 0);
    check("abort_alu_init", alu_init, 0);
    check("abort_acks", {ack0, ack1}, 0);
    rsp_q.delete();
    exp_grant.delete();
    rst = 1'b0;
    done_en = 1'b1;

    // After reset a tie goes to port 0 first.
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
    op0 = OP_ADD; a0 = 3'd1; b0 = 3'd1;
    op1 = OP_SUB; a1 = 3'd1; b1 = 3'd4;
    target = ack_count + 2;
    req1 = 1'b1; req0 = 1'b1;
    wait_acks(target);
    req0 = 1'b0; req1 = 1'b0;
    wait_drain();
    check("grants_consumed", exp_grant.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
